i2c_slave_responder: RTL and testbench

Synthesizable I2C target (slave) that answers the APB-controlled I2C master over an open-drain SDA/SCL pair. It holds a small byte register file with an auto-incrementing pointer. The file is written and read by the bus master and is visible to local logic through a read port and a write-strobe port. It replaces the behavioural slave model in system benches and serves as the on-chip target in loopback configurations.

---
 rtl/i2c_slave_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target with a small byte register file and auto-incrementing pointer.
// The bus master writes a pointer byte first, then reads or writes data bytes.
`timescale 1ns/1ps
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 8,
    parameter int         PTR_W      = 3
) (
    input  logic             pclk_i,
    input  logic             preset_ni,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             wr_strobe_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    input  logic [PTR_W-1:0] reg_idx_i,
    output logic [7:0]       reg_data_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;
    logic start_ev, stop_ev, scl_rise, scl_fall;

    state_t           state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic [7:0]       shift, shift_n;
    logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
    logic             ph, ph_n;
    logic             first, first_n;
    logic             rw, rw_n;
    logic             oe_n, busy_n, stb_n, wr_en;
    logic [PTR_W-1:0] waddr_n;
    logic [7:0]       wdata_n;
    logic [7:0]       byte_in;
    logic [7:0]       regs [NUM_REGS];

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign start_ev = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_ev  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign scl_rise = scl_s2 & ~scl_h;
    assign scl_fall = ~scl_s2 & scl_h;

    assign byte_in    = {shift[6:0], sda_s2};
    assign ptr_inc    = ptr + PTR_W'(1);
    assign reg_data_o = regs[reg_idx_i];

    // ph marks the second half of a two-step slot: ACK being driven,
    // last read bit shifted out, or master ACK seen on a read.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        ptr_n   = ptr;
        ph_n    = ph;
        first_n = first;
        rw_n    = rw;
        oe_n    = sda_oe_o;
        busy_n  = busy_o;
        stb_n   = 1'b0;
        wr_en   = 1'b0;
        waddr_n = wr_addr_o;
        wdata_n = wr_data_o;
        if (stop_ev) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            ph_n    = 1'b0;
        end else if (start_ev) begin
            state_n = ADDR;
            oe_n    = 1'b0;
            cnt_n   = 3'd0;
            ph_n    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rw_n = byte_in[0];
                            ph_n = 1'b0;
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ph) begin
                            oe_n   = 1'b1;
                            ph_n   = 1'b1;
                            busy_n = 1'b1;
                        end else begin
                            ph_n  = 1'b0;
                            cnt_n = 3'd0;
                            if (rw) begin
                                shift_n = regs[ptr];
                                oe_n    = ~regs[ptr][7];
                                state_n = RD_BYTE;
                            end else begin
                                oe_n    = 1'b0;
                                first_n = 1'b1;
                                state_n = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state_n = WR_ACK;
                            ph_n    = 1'b0;
                            if (first) begin
                                ptr_n   = byte_in[PTR_W-1:0];
                                first_n = 1'b0;
                            end else begin
                                wr_en   = 1'b1;
                                stb_n   = 1'b1;
                                waddr_n = ptr;
                                wdata_n = byte_in;
                                ptr_n   = ptr_inc;
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!ph) begin
                            oe_n = 1'b1;
                            ph_n = 1'b1;
                        end else begin
                            oe_n    = 1'b0;
                            ph_n    = 1'b0;
                            cnt_n   = 3'd0;
                            state_n = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) ph_n = 1'b1;
                    end else if (scl_fall) begin
                        if (ph) begin
                            oe_n    = 1'b0;
                            ph_n    = 1'b0;
                            cnt_n   = 3'd0;
                            state_n = RD_ACK;
                        end else begin
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !ph) begin
                        if (!sda_s2) begin
                            ptr_n   = ptr_inc;
                            shift_n = regs[ptr_inc];
                            ph_n    = 1'b1;
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end else if (scl_fall && ph) begin
                        oe_n    = ~shift[7];
                        ph_n    = 1'b0;
                        cnt_n   = 3'd0;
                        state_n = RD_BYTE;
                    end
                end
                IGNORE: oe_n = 1'b0;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            shift       <= 8'h00;
            ptr         <= '0;
            ph          <= 1'b0;
            first       <= 1'b0;
            rw          <= 1'b0;
            sda_oe_o    <= 1'b0;
            busy_o      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= 8'h00;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shift       <= shift_n;
            ptr         <= ptr_n;
            ph          <= ph_n;
            first       <= first_n;
            rw          <= rw_n;
            sda_oe_o    <= oe_n;
            busy_o      <= busy_n;
            wr_strobe_o <= stb_n;
            wr_addr_o   <= waddr_n;
            wr_data_o   <= wdata_n;
        end
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            regs[ptr] <= byte_in;
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: drives an I2C master on SCL/SDA and checks the target's
// ACKs, read data, write strobes and register file contents.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic [2:0] reg_idx;
    logic       sda_oe, busy, stb;
    logic [2:0] waddr;
    logic [7:0] wdata, rdata;
    logic       sda_line;

    int total = 0;
    int bad   = 0;

    logic [15:0] stb_log [32];
    int          stb_cnt = 0;
    int          oe_cnt  = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_responder #(
        .SLAVE_ADDR(7'h50),
        .NUM_REGS  (8),
        .PTR_W     (3)
    ) dut (
        .pclk_i     (clk),
        .preset_ni  (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe_o   (sda_oe),
        .busy_o     (busy),
        .wr_strobe_o(stb),
        .wr_addr_o  (waddr),
        .wr_data_o  (wdata),
        .reg_idx_i  (reg_idx),
        .reg_data_o (rdata)
    );

    always @(negedge clk) begin
        if (stb) begin
            if (stb_cnt < 32) stb_log[stb_cnt] <= {5'b0, waddr, wdata};
            stb_cnt <= stb_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (5) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic wbits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; q();
            scl_m = 1'b1; q(); q();
            scl_m = 1'b0; q();
        end
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        wbits(b, 8);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        ack = ~sda_line; q();
        scl_m = 1'b0; q();
    endtask

    task automatic rbyte(output logic [7:0] b, input logic mack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            q();
            scl_m = 1'b1; q();
            b[i] = sda_line; q();
            scl_m = 1'b0; q();
        end
        sda_m = mack; q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         s0, o0;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; reg_idx = 3'd0;
        repeat (4) @(negedge clk);
        check("rst_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_stb", stb, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_reg0", rdata, 0);
        rst_n = 1'b1;
        q();

        // write ptr 2, data A5, 3C
        s0 = stb_cnt;
        i2c_start();
        wbyte(8'hA0, a); check("t1_ack_addr", a, 1);
        check("t1_busy", busy, 1);
        wbyte(8'h02, a); check("t1_ack_ptr", a, 1);
        wbyte(8'hA5, a); check("t1_ack_d0", a, 1);
        wbyte(8'h3C, a); check("t1_ack_d1", a, 1);
        i2c_stop(); q();
        check("t1_nstb", stb_cnt - s0, 2);
        check("t1_stb0", stb_log[s0], 16'h02A5);
        check("t1_stb1", stb_log[s0+1], 16'h033C);
        reg_idx = 3'd3; #1;
        check("t1_reg3", rdata, 8'h3C);
        reg_idx = 3'd2; #1;
        check("t1_reg2", rdata, 8'hA5);
        check("t1_busy_off", busy, 0);

        // pointer write, repeated START, read three bytes
        i2c_start();
        wbyte(8'hA0, a); check("t2_ack_addr", a, 1);
        wbyte(8'h02, a); check("t2_ack_ptr", a, 1);
        i2c_start();
        wbyte(8'hA1, a); check("t2_ack_raddr", a, 1);
        rbyte(d, 1'b0); check("t2_rd0", d, 8'hA5);
        rbyte(d, 1'b0); check("t2_rd1", d, 8'h3C);
        rbyte(d, 1'b1); check("t2_rd2", d, 8'h00);
        check("t2_oe_nack", sda_oe, 0);
        check("t2_busy_nack", busy, 0);
        check("t2_ptr", dut.ptr, 4);
        i2c_stop(); q();

        // wrong address: nothing driven, nothing written
        s0 = stb_cnt; o0 = oe_cnt;
        i2c_start();
        wbyte(8'hA2, a); check("t3_nack_addr", a, 0);
        wbyte(8'h00, a); check("t3_nack_b1", a, 0);
        wbyte(8'h55, a); check("t3_nack_b2", a, 0);
        check("t3_busy", busy, 0);
        i2c_stop(); q();
        check("t3_oe_never", oe_cnt - o0, 0);
        check("t3_nstb", stb_cnt - s0, 0);
        check("t3_idle", dut.state, 0);

        // pointer wrap, then oversized pointer byte
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h07, a);
        wbyte(8'h11, a); check("t4_ack_d0", a, 1);
        wbyte(8'h22, a); check("t4_ack_d1", a, 1);
        i2c_stop(); q();
        reg_idx = 3'd7; #1;
        check("t4_reg7", rdata, 8'h11);
        reg_idx = 3'd0; #1;
        check("t4_reg0", rdata, 8'h22);
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'hFF, a); check("t4_ack_ff", a, 1);
        i2c_stop(); q();
        check("t4_ptr_ff", dut.ptr, 7);

        // STOP after four bits of a data byte
        s0 = stb_cnt;
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h01, a);
        wbits(8'hF0, 4);
        i2c_stop(); q();
        check("t5_nstb", stb_cnt - s0, 0);
        check("t5_idle", dut.state, 0);
        check("t5_oe", sda_oe, 0);
        check("t5_busy", busy, 0);
        reg_idx = 3'd1; #1;
        check("t5_reg1", rdata, 8'h00);
        i2c_start();
        wbyte(8'hA0, a); check("t5_ack_addr", a, 1);
        wbyte(8'h05, a);
        wbyte(8'h77, a); check("t5_ack_d", a, 1);
        i2c_stop(); q();
        check("t5_nstb2", stb_cnt - s0, 1);
        check("t5_stb", stb_log[s0], 16'h0577);
        reg_idx = 3'd5; #1;
        check("t5_reg5", rdata, 8'h77);

        // async reset while the target drives a 0 read bit
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h03, a);
        i2c_start();
        wbyte(8'hA1, a); check("t6_ack_raddr", a, 1);
        check("t6_oe_drv", sda_oe, 1);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check("t6_oe_rst", sda_oe, 0);
        check("t6_busy_rst", busy, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        q();
        rst_n = 1'b1;
        q();
        reg_idx = 3'd0; #1; check("t6_reg0", rdata, 8'h00);
        reg_idx = 3'd2; #1; check("t6_reg2", rdata, 8'h00);
        reg_idx = 3'd3; #1; check("t6_reg3", rdata, 8'h00);
        reg_idx = 3'd7; #1; check("t6_reg7", rdata, 8'h00);
        check("t6_ptr", dut.ptr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
